// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the sys_ctrl command-frame controller.
package sys_ctrl_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

endpackage

// File: rtl/sys_ctrl.sv
// Decodes write/read command frames from a byte stream into register-file
// strobes and returns read data to the transmitter; all outputs registered.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [WIDTH-1:0]      RdData,
  input  logic                  RdData_Valid,
  input  logic                  TX_Busy,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [WIDTH-1:0]      WrData,
  output logic [WIDTH-1:0]      TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  ERR
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [WIDTH-1:0] CMD_WR_W = WIDTH'(CMD_WR);
  localparam logic [WIDTH-1:0] CMD_RD_W = WIDTH'(CMD_RD);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [WIDTH-1:0]      tx_data_q, tx_data_d;
  logic [WIDTH-1:0]      tx_buf_q, tx_buf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  err_q, err_d;

  // Next-state and next-output decode for the frame FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    address_d = address_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    tx_buf_d  = tx_buf_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR_W) begin
            state_d = WR_ADDR;
          end else if (RX_P_DATA == CMD_RD_W) begin
            state_d = RD_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end else begin
          state_d = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_data_d = RX_P_DATA;
          state_d   = IDLE;
        end else begin
          state_d = WR_DATA;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d    = RX_P_DATA[ADDR_WIDTH-1:0];
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d   = 1'b1;
          cnt_d     = CW'(0);
          state_d   = RD_WAIT;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_WAIT: begin
        // A stray command byte is dropped; the read in flight continues.
        err_d = RX_D_VLD;
        if (RdData_Valid) begin
          tx_buf_d = RdData;
          cnt_d    = CW'(0);
          state_d  = TX_SEND;
        end else if (cnt_q == CW'(RD_TIMEOUT)) begin
          err_d   = 1'b1;
          cnt_d   = CW'(0);
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_SEND: begin
        err_d = RX_D_VLD;
        if (!TX_Busy) begin
          tx_vld_d  = 1'b1;
          tx_data_d = tx_buf_q;
          state_d   = IDLE;
        end else begin
          state_d = TX_SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      address_q <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      tx_buf_q  <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      tx_buf_q  <= tx_buf_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_vld_q  <= tx_vld_d;
      err_q     <= err_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = address_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed self-checking bench for sys_ctrl: write/read frames, busy stall,
// read timeout, bad command, stray bytes and mid-frame reset.
module tb_sys_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_vld = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       rd_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       wr_en, rd_en, tx_vld, err;
  logic [3:0] address;
  logic [7:0] wr_data, tx_data;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0, both_cnt = 0;
  int wr0, rd0, tx0, err0;
  int first_err;

  sys_ctrl #(.WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(4)) dut (
    .CLK(clk), .RST(rst), .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
    .RdData(rd_data), .RdData_Valid(rd_valid), .TX_Busy(tx_busy),
    .WrEn(wr_en), .RdEn(rd_en), .Address(address), .WrData(wr_data),
    .TX_P_DATA(tx_data), .TX_D_VLD(tx_vld), .ERR(err)
  );

  always #5 clk = ~clk;

  // Strobe pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (tx_vld) tx_cnt <= tx_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (wr_en && rd_en) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    step();
    rx_vld  = 1'b0;
  endtask

  task automatic snap();
    wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_cnt; err0 = err_cnt;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wren"},  {31'd0, wr_en},  32'd0);
    check({tag, "_rden"},  {31'd0, rd_en},  32'd0);
    check({tag, "_txvld"}, {31'd0, tx_vld}, 32'd0);
    check({tag, "_err"},   {31'd0, err},    32'd0);
    check({tag, "_addr"},  {28'd0, address}, 32'd0);
    check({tag, "_wdata"}, {24'd0, wr_data}, 32'd0);
    check({tag, "_txdata"}, {24'd0, tx_data}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Write frame AA,05,3C
    snap();
    send(8'hAA); send(8'h05); send(8'h3C);
    check("wr_en",   {31'd0, wr_en}, 32'd1);
    check("wr_addr", {28'd0, address}, 32'h5);
    check("wr_data", {24'd0, wr_data}, 32'h3C);
    step();
    check("wr_en_drop", {31'd0, wr_en}, 32'd0);
    check("wr_addr_hold", {28'd0, address}, 32'h5);
    check("wr_data_hold", {24'd0, wr_data}, 32'h3C);
    check("wr_pulses", wr_cnt - wr0, 32'd1);
    check("wr_no_rd", rd_cnt - rd0, 32'd0);

    // Read frame BB,02 returning 0x21 one cycle after RdEn
    snap();
    send(8'hBB); send(8'h02);
    check("rd_en", {31'd0, rd_en}, 32'd1);
    check("rd_addr", {28'd0, address}, 32'h2);
    step();
    check("rd_en_drop", {31'd0, rd_en}, 32'd0);
    rd_data = 8'h21; rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    step();
    check("tx_vld", {31'd0, tx_vld}, 32'd1);
    check("tx_data", {24'd0, tx_data}, 32'h21);
    step();
    check("tx_vld_drop", {31'd0, tx_vld}, 32'd0);
    check("tx_data_hold", {24'd0, tx_data}, 32'h21);
    check("rd_tx_pulses", tx_cnt - tx0, 32'd1);
    check("rd_no_wr", wr_cnt - wr0, 32'd0);

    // Read frame BB,03 with transmitter busy for 10 cycles
    snap();
    tx_busy = 1'b1;
    send(8'hBB); send(8'h03);
    step();
    rd_data = 8'h5A; rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("busy_no_tx", tx_cnt - tx0, 32'd0);
    tx_busy = 1'b0;
    step();
    check("busy_tx_vld", {31'd0, tx_vld}, 32'd1);
    check("busy_tx_data", {24'd0, tx_data}, 32'h5A);
    step(); step();
    check("busy_tx_once", tx_cnt - tx0, 32'd1);

    // Read frame BB,01 with no read data: timeout
    snap();
    send(8'hBB); send(8'h01);
    first_err = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (err && first_err < 0) first_err = i;
    end
    check("timeout_seen", {31'd0, (first_err >= 4 && first_err <= 5)}, 32'd1);
    check("timeout_err_once", err_cnt - err0, 32'd1);
    check("timeout_no_tx", tx_cnt - tx0, 32'd0);

    // Bad command 0x55 then back-to-back write AA,0F,FF
    snap();
    send(8'h55);
    check("bad_cmd_err", {31'd0, err}, 32'd1);
    check("bad_cmd_no_wr", {31'd0, wr_en}, 32'd0);
    check("bad_cmd_no_rd", {31'd0, rd_en}, 32'd0);
    send(8'hAA); send(8'h0F); send(8'hFF);
    check("b2b_wr_en", {31'd0, wr_en}, 32'd1);
    check("b2b_addr", {28'd0, address}, 32'hF);
    check("b2b_data", {24'd0, wr_data}, 32'hFF);
    step();

    // Reset mid-frame after AA,07, then 0x99 is decoded as a command
    snap();
    send(8'hAA); send(8'h07);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    send(8'h99);
    check("post_rst_err", {31'd0, err}, 32'd1);
    step();
    check("post_rst_no_wr", wr_cnt - wr0, 32'd0);

    // Stray byte during RD_WAIT is dropped with ERR; read completes
    snap();
    send(8'hBB); send(8'h04);
    send(8'h77);
    check("stray_err", {31'd0, err}, 32'd1);
    rd_data = 8'h42; rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    step();
    check("stray_tx_vld", {31'd0, tx_vld}, 32'd1);
    check("stray_tx_data", {24'd0, tx_data}, 32'h42);
    step();
    check("never_wr_and_rd", both_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data byte and register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 SHALL have parameter RD_TIMEOUT, default 4, maximum cycles to wait for read data.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port RX_P_DATA  input  WIDTH  received command byte.
REQ-007 SHALL have port RX_D_VLD  input  1  RX_P_DATA valid for this cycle only.
REQ-008 SHALL have port RdData  input  WIDTH  register-file read data.
REQ-009 SHALL have port RdData_Valid  input  1  RdData valid pulse.
REQ-010 SHALL have port TX_Busy  input  1  transmitter cannot accept a byte.
REQ-011 SHALL have port WrEn  output  1  register-file write strobe.
REQ-012 SHALL have port RdEn  output  1  register-file read strobe.
REQ-013 SHALL have port Address  output  ADDR_WIDTH  register-file address.
REQ-014 SHALL have port WrData  output  WIDTH  register-file write data.
REQ-015 SHALL have port TX_P_DATA  output  WIDTH  byte to transmit.
REQ-016 SHALL have port TX_D_VLD  output  1  TX_P_DATA valid pulse.
REQ-017 SHALL have port ERR  output  1  one-cycle pulse on dropped or timed-out frame.

Function
REQ-018 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
REQ-019 In IDLE: RX_D_VLD with 0xAA -> WR_ADDR; with 0xBB -> RD_ADDR; other byte -> stay IDLE, pulse ERR next cycle.
REQ-020 In WR_ADDR: on RX_D_VLD, latch RX_P_DATA[ADDR_WIDTH-1:0] as address, ignore upper bits, -> WR_DATA.
REQ-021 In WR_DATA: on RX_D_VLD, the next cycle drives WrEn=1, Address=latched address, and WrData=byte for exactly one cycle, then -> IDLE.
REQ-022 In RD_ADDR: on RX_D_VLD, latch address; the next cycle drives RdEn=1 for exactly one cycle with Address valid, then -> RD_WAIT.
REQ-023 In RD_WAIT: on RdData_Valid, capture RdData into a tx buffer and -> TX_SEND; expected latency is 1 cycle after RdEn.
REQ-024 In RD_WAIT: a wait counter shall run; if RdData_Valid is absent for RD_TIMEOUT cycles after RdEn, pulse ERR and -> IDLE.
REQ-025 In TX_SEND: in the first cycle with TX_Busy=0, assert TX_D_VLD=1 with TX_P_DATA=buffer for exactly one cycle, then -> IDLE; wait indefinitely while TX_Busy=1.
REQ-026 WrEn and RdEn SHALL never be asserted in the same cycle.
REQ-027 All outputs SHALL be registered; strobes default to 0 every cycle unless asserted per REQ-021/022/025.
REQ-028 RX_D_VLD received during RD_WAIT or TX_SEND SHALL be dropped with an ERR pulse; state is unchanged.
REQ-029 Address, WrData, and TX_P_DATA SHALL hold their last values when their strobes are low.
REQ-030 Back-to-back frames SHALL be accepted: a command byte arriving in the cycle after a return to IDLE is decoded normally.

Reset
REQ-031 RST=1 at a clock edge SHALL force IDLE and clear WrEn, RdEn, TX_D_VLD, ERR, Address, WrData, TX_P_DATA, the tx buffer, and the wait counter to 0.
REQ-032 RST mid-frame SHALL abandon the frame with no write, read, or tx strobe; the next byte after reset is decoded as a command.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the CMD_WR=0xAA and CMD_RD=0xBB constants, and the WIDTH/ADDR_WIDTH defaults.
REQ-034 The block SHALL be single-module; the wait counter stays inline, and no sub-module is needed.

Verification
REQ-035 Write frame AA,05,3C -> one cycle with WrEn=1, Address=5, WrData=0x3C; RdEn stays 0 throughout.
REQ-036 Read frame BB,02 with RdData=0x21 returned 1 cycle after RdEn and TX_Busy=0 -> single TX_D_VLD pulse, TX_P_DATA=0x21.
REQ-037 Read frame BB,03 with TX_Busy held 1 for 10 cycles -> TX_D_VLD asserts on the first cycle after TX_Busy falls, once only.
REQ-038 Read frame BB,01 with RdData_Valid never asserted -> ERR pulse after 4 cycles, FSM in IDLE, no TX_D_VLD.
REQ-039 Byte 0x55 in IDLE -> ERR pulse and no strobes; the following AA,0F,FF frame -> WrEn with Address=0xF, WrData=0xFF.
REQ-040 RST pulsed after AA,07 -> no WrEn; the subsequent byte 0x99 is treated as a command, giving an ERR pulse.
